// File: rtl/demux1to4_32bit_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_pkg
//  Description : Shared types and constants for the registered 1-to-4 word
//                demultiplexer (demux1to4_32bit_pipe) and its slot sub-block.
//                  DATA_W  - word width
//                  NUM_CH  - number of output channels (2-bit select -> 4)
//                  CNT_W   - width of the optional per-channel counters
//                Optional feature macro: DEMUX_CNT_EN (per-channel counters).
//  Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    localparam int DATA_W = 32;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;

    typedef logic [1:0]        ch_sel_t;
    typedef logic [DATA_W-1:0] word_t;

    // Occupancy of a one-entry output slot.
    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // One-hot decode of a channel select.
    function automatic logic [NUM_CH-1:0] sel_onehot(input ch_sel_t sel);
        logic [NUM_CH-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux1to4_32bit_pipe_slot.sv
`default_nettype none
// ============================================================================
//  Module      : demux_slot
//  Description : One-entry output holding register with a valid/ready drain
//                side. A load and a drain in the same cycle refill the slot
//                without a bubble. Optionally counts delivered words.
//  Ports       : clk, rst_n      - clock, asynchronous active-low reset
//                load            - write load_data into the slot this edge
//                load_data       - word to store
//                slot_ready      - slot can take a word this cycle
//                out_valid       - slot holds a word
//                out_ready       - consumer takes the word this cycle
//                out_data        - held word (held while empty)
//                cnt_clr/out_cnt - counter clear / delivered count
//                                  (only with DEMUX_CNT_EN)
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_slot
    import demux_pkg::*;
#(
    parameter int SLOT_W = DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [SLOT_W-1:0] load_data,
    output logic              slot_ready,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef DEMUX_CNT_EN
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  out_cnt,
`endif
    output logic [SLOT_W-1:0] out_data
);

    localparam logic [0:0] c_ST_EMPTY = SLOT_EMPTY;
    localparam logic [0:0] c_ST_FULL  = SLOT_FULL;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [SLOT_W-1:0] r_data;
    logic              w_drain;

    // A drain is a completed output handshake.
    // A load takes priority over a drain so a same-cycle refill stays FULL.
    always_comb begin
        w_drain     = (r_state == c_ST_FULL) && out_ready;
        w_state_nxt = r_state;
        if (load) begin
            w_state_nxt = c_ST_FULL;
        end else if (w_drain) begin
            w_state_nxt = c_ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_EMPTY;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (load) begin
                r_data <= load_data;
            end
        end
    end

    assign out_valid  = (r_state == c_ST_FULL);
    assign out_data   = r_data;
    // The slot can take a word when it is empty or is being drained now.
    assign slot_ready = (r_state == c_ST_EMPTY) || out_ready;

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Clear wins over a coincident handshake; natural wrap at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_drain) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out_cnt = r_cnt;
`endif

endmodule
`default_nettype wire

// File: rtl/demux1to4_32bit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : demux1to4_32bit_pipe
//  Description : Registered 1-to-4 demultiplexer. One word per cycle enters
//                on a valid/ready channel and is steered by in_sel into one
//                of four independent one-entry slots, each draining through
//                its own valid/ready channel. A stalled channel only blocks
//                words addressed to it.
//  Ports       : clk, rst_n - clock, asynchronous active-low reset
//                in_valid/in_ready/in_sel/in_data - input channel
//                out_valid[i]/out_ready[i]        - per-channel handshake
//                out_data  - channel i at [DATA_W*i +: DATA_W]
//                cnt_clr/out_cnt - counter clear / per-channel delivered
//                                  counts at [16*i +: 16]
//  Config      : DEMUX_CNT_EN - adds cnt_clr/out_cnt and the counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux1to4_32bit_pipe #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [1:0]                          in_sel,
    input  logic [DATA_W-1:0]                   in_data,
    output logic [NUM_CH-1:0]                   out_valid,
    input  logic [NUM_CH-1:0]                   out_ready,
`ifdef DEMUX_CNT_EN
    input  logic                                cnt_clr,
    output logic [NUM_CH*demux_pkg::CNT_W-1:0]  out_cnt,
`endif
    output logic [NUM_CH*DATA_W-1:0]            out_data
);

    import demux_pkg::*;

    logic [NUM_CH-1:0] w_sel_oh;
    logic [NUM_CH-1:0] w_slot_rdy;
    logic              w_accept;

    assign w_sel_oh = sel_onehot(ch_sel_t'(in_sel));

    // Ready looks only at the addressed slot, so other stalled channels
    // never hold up this word.
    assign in_ready = w_slot_rdy[in_sel];
    assign w_accept = in_valid && in_ready;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
        demux_slot #(
            .SLOT_W     (DATA_W)
        ) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (w_accept && w_sel_oh[gi]),
            .load_data  (in_data),
            .slot_ready (w_slot_rdy[gi]),
            .out_valid  (out_valid[gi]),
            .out_ready  (out_ready[gi]),
`ifdef DEMUX_CNT_EN
            .cnt_clr    (cnt_clr),
            .out_cnt    (out_cnt[gi*CNT_W +: CNT_W]),
`endif
            .out_data   (out_data[gi*DATA_W +: DATA_W])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_demux1to4_32bit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux1to4_32bit_pipe
//  Description : Self-checking bench for demux1to4_32bit_pipe. A per-channel
//                occupancy model tracks what each slot must hold; a compare
//                process checks it every cycle, and directed steps pin
//                hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux1to4_32bit_pipe;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_sel;
    logic [31:0]  in_data;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [127:0] out_data;
`ifdef DEMUX_CNT_EN
    logic         cnt_clr;
    logic [63:0]  out_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    demux1to4_32bit_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef DEMUX_CNT_EN
        .cnt_clr   (cnt_clr),
        .out_cnt   (out_cnt),
`endif
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Each channel: does it hold a word, which word was last stored,
    // and how many words has it handed out.
    logic        m_full [4];
    logic [31:0] m_word [4];
    logic [15:0] m_dlv  [4];
    logic        m_in_ok;

    always_comb m_in_ok = !m_full[in_sel] || out_ready[in_sel];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 4; c++) begin
                m_full[c] <= 1'b0;
                m_word[c] <= 32'h0;
                m_dlv[c]  <= 16'h0;
            end
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (in_valid && m_in_ok && (int'(in_sel) == c)) begin
                    m_full[c] <= 1'b1;
                    m_word[c] <= in_data;
                end else if (m_full[c] && out_ready[c]) begin
                    m_full[c] <= 1'b0;
                end
`ifdef DEMUX_CNT_EN
                if (cnt_clr)
                    m_dlv[c] <= 16'h0;
                else if (m_full[c] && out_ready[c])
                    m_dlv[c] <= m_dlv[c] + 16'h1;
`endif
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Compare the DUT against the model on every falling edge out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            logic [3:0]   ev;
            logic [127:0] ed;
            logic [63:0]  ec;
            for (int c = 0; c < 4; c++) begin
                ev[c]           = m_full[c];
                ed[c*32 +: 32]  = m_word[c];
                ec[c*16 +: 16]  = m_dlv[c];
            end
            check("model_out_valid", 128'(out_valid), 128'(ev));
            check("model_in_ready",  128'(in_ready),  128'(m_in_ok));
            check("model_out_data",  out_data, ed);
`ifdef DEMUX_CNT_EN
            check("model_out_cnt",   128'(out_cnt), 128'(ec));
`else
            if (ec != 64'h0) check("model_cnt_idle", 128'(ec), 128'h0);
`endif
        end
    end

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = 32'h0;
        out_ready = 4'b0;
`ifdef DEMUX_CNT_EN
        cnt_clr   = 1'b0;
`endif
        #12 rst_n = 1'b1;
        tick();

        // Reset state
        check("reset_out_valid", 128'(out_valid), 128'h0);
        check("reset_in_ready",  128'(in_ready),  128'h1);
        check("reset_out_data",  out_data,        128'h0);

        // Single route to channel 2
        in_valid = 1'b1; in_sel = 2'd2; in_data = 32'hDEADBEEF;
        tick();
        in_valid = 1'b0;
        check("route_valid", 128'(out_valid), 128'(4'b0100));
        check("route_data2", 128'(out_data[95:64]), 128'(32'hDEADBEEF));
        out_ready = 4'b0100;
        tick();
        out_ready = 4'b0000;
        check("route_drain", 128'(out_valid), 128'h0);

        // Back-pressure isolation: channel 1 stalled
        in_valid = 1'b1; in_sel = 2'd1; in_data = 32'hA1A1A1A1;
        tick();
        in_sel = 2'd3; in_data = 32'h12345678;
        #1 check("bp_ready_ch3", 128'(in_ready), 128'h1);
        tick();
        check("bp_valid_13", 128'(out_valid), 128'(4'b1010));
        check("bp_data3", 128'(out_data[127:96]), 128'(32'h12345678));
        in_sel = 2'd1; in_data = 32'hB2B2B2B2;
        #1 check("bp_ready_ch1", 128'(in_ready), 128'h0);
        tick();
        tick();
        check("bp_hold_data1", 128'(out_data[63:32]), 128'(32'hA1A1A1A1));
        out_ready = 4'b0010;
        #1 check("bp_ready_rise", 128'(in_ready), 128'h1);
        tick();
        in_valid = 1'b0;
        check("bp_refill_data1", 128'(out_data[63:32]), 128'(32'hB2B2B2B2));
        check("bp_refill_valid", 128'(out_valid), 128'(4'b1010));
        out_ready = 4'b1010;
        tick();
        out_ready = 4'b0000;
        check("bp_drained", 128'(out_valid), 128'h0);

        // Pass-through on channel 0 with consumer always ready
        out_ready = 4'b0001; in_valid = 1'b1; in_sel = 2'd0;
        for (int k = 1; k <= 3; k++) begin
            in_data = 32'(k);
            #1 check("pt_in_ready", 128'(in_ready), 128'h1);
            tick();
            check("pt_data0", 128'(out_data[31:0]), 128'(k));
            check("pt_valid0", 128'(out_valid), 128'(4'b0001));
        end
        in_valid = 1'b0;
        tick();
        check("pt_empty", 128'(out_valid), 128'h0);

        // Accept on channel 2 while channel 0 drains
        out_ready = 4'b0000; in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h0000_00AA;
        tick();
        out_ready = 4'b0001; in_sel = 2'd2; in_data = 32'h0000_00BB;
        tick();
        in_valid = 1'b0; out_ready = 4'b0000;
        check("cross_valid", 128'(out_valid), 128'(4'b0100));
        check("cross_data2", 128'(out_data[95:64]), 128'(32'h0000_00BB));

        // Fill all four, then drain all four in one cycle
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_sel = 2'(c); in_data = 32'hC0DE_0000 | 32'(c);
            tick();
        end
        in_valid = 1'b0;
        check("fill_all", 128'(out_valid), 128'(4'b1111));
        out_ready = 4'b1111;
        tick();
        out_ready = 4'b0000;
        check("drain_all", 128'(out_valid), 128'h0);

        // Refill all four, then reset between edges
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_sel = 2'(c); in_data = 32'hF00D_0000 | 32'(c);
            tick();
        end
        in_valid = 1'b0;
        check("refill_all", 128'(out_valid), 128'(4'b1111));
        #1 rst_n = 1'b0;
        #1;
        check("midrst_valid", 128'(out_valid), 128'h0);
        check("midrst_data",  out_data,        128'h0);
`ifdef DEMUX_CNT_EN
        check("midrst_cnt",   128'(out_cnt),   128'h0);
`endif
        #1 rst_n = 1'b1;
        tick();
        check("post_rst_ready", 128'(in_ready), 128'h1);

`ifdef DEMUX_CNT_EN
        // 65537 handshakes on channel 0 wrap the counter to 1
        out_ready = 4'b0001; in_valid = 1'b1; in_sel = 2'd0;
        for (int k = 0; k < 65537; k++) begin
            in_data = 32'(k);
            tick();
        end
        in_valid = 1'b0;
        tick();
        out_ready = 4'b0000;
        check("cnt_wrap", 128'(out_cnt[15:0]), 128'h1);

        // Two handshakes on channel 1, then a third coinciding with clear
        out_ready = 4'b0010; in_valid = 1'b1; in_sel = 2'd1;
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        check("cnt_ch1_two", 128'(out_cnt[31:16]), 128'h2);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0; out_ready = 4'b0000;
        check("cnt_clr_wins", 128'(out_cnt), 128'h0);
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
